// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the divider state encoding, datapath widths and the W-form sign-extend helper.
package mdu_pkg;

    localparam int XLEN = 64;
    localparam int WLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/div_sign_adjust.sv
// Per-lane conditional negate followed by W-form narrowing (zero- or sign-extension).
// Used on entry to take operand magnitudes and on exit to restore result signs.
module div_sign_adjust #(
    parameter int XLEN  = 64,
    parameter int LANES = 2
) (
    input  logic [LANES-1:0][XLEN-1:0] val,
    input  logic [LANES-1:0]           neg,
    input  logic                       w_mode,
    input  logic                       ext_signed,
    output logic [LANES-1:0][XLEN-1:0] res
);
    import mdu_pkg::*;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XLEN-1:0] mag;

        assign mag = neg[i] ? (~val[i]) + {{(XLEN-1){1'b0}}, 1'b1} : val[i];

        // W operands are zero-extended magnitudes; W results are sign-extended from bit 31
        assign res[i] = !w_mode    ? mag :
                        ext_signed ? sext32(mag[WLEN-1:0]) :
                                     {{(XLEN-WLEN){1'b0}}, mag[WLEN-1:0]};
    end

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module iter_divider #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    import mdu_pkg::*;

    div_state_e      state, state_nxt;
    logic [6:0]      cnt;
    logic [XLEN:0]   pr;
    logic [XLEN-1:0] qr;
    logic [XLEN-1:0] dvs;
    logic            w_mode, q_neg, r_neg;

    logic a_neg, b_neg, div_zero, ovf, accept, last_step;
    logic [1:0][XLEN-1:0] ent_out, ext_in, ext_out;

    assign out_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    assign a_neg    = div_signed & (divw ? dividend[WLEN-1] : dividend[XLEN-1]);
    assign b_neg    = div_signed & (divw ? divisor[WLEN-1]  : divisor[XLEN-1]);
    assign div_zero = divw ? (divisor[WLEN-1:0] == '0) : (divisor == '0);
    assign ovf      = div_signed & (divw ?
                      (dividend[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}} && divisor[WLEN-1:0] == '1) :
                      (dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1));
    assign accept    = in_valid & out_ready & ~flush;
    assign last_step = (state == BUSY) && (cnt == 7'd1);

    div_sign_adjust #(.XLEN(XLEN), .LANES(2)) u_entry (
        .val        ({divisor, dividend}),
        .neg        ({b_neg, a_neg}),
        .w_mode     (divw),
        .ext_signed (1'b0),
        .res        (ent_out)
    );

    // One restoring step: shift in the next dividend bit, trial-subtract, keep if non-negative
    logic [XLEN+1:0] pr_sh, diff;
    logic [XLEN:0]   pr_step;
    logic [XLEN-1:0] qr_step;
    logic            qbit;

    assign pr_sh   = {pr, qr[XLEN-1]};
    assign diff    = pr_sh - {2'b00, dvs};
    assign qbit    = ~diff[XLEN+1];
    assign pr_step = qbit ? diff[XLEN:0] : pr_sh[XLEN:0];
    assign qr_step = {qr[XLEN-2:0], qbit};

    assign ext_in = {pr_step[XLEN-1:0], qr_step};

    div_sign_adjust #(.XLEN(XLEN), .LANES(2)) u_exit (
        .val        (ext_in),
        .neg        ({r_neg, q_neg}),
        .w_mode     (w_mode),
        .ext_signed (1'b1),
        .res        (ext_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (div_zero | ovf) ? DONE : BUSY;
            BUSY:    if (cnt == 7'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            pr        <= '0;
            qr        <= '0;
            dvs       <= '0;
            w_mode    <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (!flush) begin
            if (accept) begin
                w_mode <= divw;
                q_neg  <= a_neg ^ b_neg;
                r_neg  <= a_neg;
                cnt    <= divw ? 7'(WLEN) : 7'(XLEN);
                pr     <= '0;
                dvs    <= ent_out[1];
                // W dividends are left-aligned so the MSB-first shift starts at bit 31
                qr     <= divw ? {ent_out[0][WLEN-1:0], {(XLEN-WLEN){1'b0}}} : ent_out[0];
                if (div_zero) begin
                    quotient  <= '1;
                    remainder <= divw ? sext32(dividend[WLEN-1:0]) : dividend;
                end else if (ovf) begin
                    quotient  <= divw ? sext32(dividend[WLEN-1:0]) : dividend;
                    remainder <= '0;
                end
            end else if (state == BUSY) begin
                pr  <= pr_step;
                qr  <= qr_step;
                cnt <= cnt - 7'd1;
                if (last_step) begin
                    quotient  <= ext_out[0];
                    remainder <= ext_out[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: an arithmetic reference model predicts results and latency,
// and a per-cycle compare process checks handshake and held results against it.
module tb_iter_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        divw = 1'b0;
    logic        div_signed = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        out_ready, out_valid;
    logic [63:0] quotient, remainder;

    iter_divider #(.XLEN(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .divw       (divw),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int errs = 0;
    int checks = 0;

    // expectation for the single in-flight operation
    bit          act_valid = 1'b0;
    int          act_start = 0;
    int          act_end = 0;
    logic [63:0] act_q = '0, act_r = '0;
    logic [63:0] hold_q = '0, hold_r = '0;
    string       cur = "reset";

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: RISC-V division semantics computed with plain arithmetic
    task automatic model(input bit w, input bit s, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
        if (w) begin
            logic [31:0] a32, b32, q32, r32;
            a32 = a[31:0];
            b32 = b[31:0];
            lat = 33;
            if (b32 == 0) begin
                q32 = '1; r32 = a32; lat = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0; lat = 1;
            end else if (s) begin
                int sa, sb;
                sa = a32; sb = b32;
                q32 = sa / sb; r32 = sa % sb;
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            lat = 65;
            if (b == 0) begin
                q = '1; r = a; lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0; lat = 1;
            end else if (s) begin
                longint sa, sb;
                sa = a; sb = b;
                q = sa / sb; r = sa % sb;
            end else begin
                q = a / b; r = a % b;
            end
        end
    endtask

    // Sampled on the falling edge; the driver updates expectations 1ns later
    always @(negedge clock) begin
        bit ev, er;
        ev = act_valid && (cyc == act_end);
        er = !(act_valid && cyc > act_start && cyc <= act_end);
        chk({cur, " out_valid"}, 64'(out_valid), 64'(ev));
        chk({cur, " out_ready"}, 64'(out_ready), 64'(er));
        if (ev) begin
            hold_q = act_q;
            hold_r = act_r;
        end
        chk({cur, " quotient"}, quotient, hold_q);
        chk({cur, " remainder"}, remainder, hold_r);
    end

    task automatic start_op(input string nm, input bit w, input bit s, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er);
        logic [63:0] mq, mr;
        int lat;
        model(w, s, a, b, mq, mr, lat);
        chk({nm, " model q"}, mq, eq);
        chk({nm, " model r"}, mr, er);
        cur        = nm;
        divw       = w;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        in_valid   = 1'b1;
        act_valid  = 1'b1;
        act_start  = cyc;
        act_end    = cyc + lat;
        act_q      = mq;
        act_r      = mr;
    endtask

    // Keeps in_valid high with junk operands while busy; the divider must ignore them
    task automatic junk_cycle();
        @(negedge clock); #1;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        divw       = 1'($urandom);
        div_signed = 1'($urandom);
    endtask

    task automatic finish_op();
        junk_cycle();
        while (cyc < act_end) junk_cycle();
        in_valid = 1'b0;
        @(negedge clock); #1;
    endtask

    task automatic run_op(input string nm, input bit w, input bit s, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er);
        start_op(nm, w, s, a, b, eq, er);
        finish_op();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        #1;
        chk("reset out_ready", 64'(out_ready), 64'd1);
        reset = 1'b1;
        @(negedge clock); #1;

        run_op("udiv 100/7",   0, 0, 64'd100, 64'd7, 64'd14, 64'd2);
        run_op("sdiv -7/2",    0, 1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sdiv 7/-2",    0, 1, 64'd7, -64'sd2, -64'sd3, 64'd1);
        run_op("div by zero",  0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        run_op("sdiv ovf",     0, 1, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0);
        run_op("divuw",        1, 0, 64'h1_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_op("divw -7/2",    1, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divuw small",  1, 0, 64'hDEAD_0000_8000_0000, 64'd3, 64'h2AAA_AAAA, 64'd2);
        run_op("divw ovf",     1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0);
        run_op("divw by zero", 1, 1, 64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000, '1, 64'hFFFF_FFFF_8000_0001);
        run_op("udiv wide",    0, 0, '1, 64'h1_0000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        run_op("sdiv neg/neg", 0, 1, -64'sd100, -64'sd7, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("udiv small",   0, 0, 64'd5, 64'd9, 64'd0, 64'd5);
        run_op("udiv msb dvs", 0, 0, '1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF);
        run_op("udiv not ovf", 0, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 64'h8000_0000_0000_0000);

        // flush wins over a same-cycle accept in IDLE
        cur = "flush idle";
        divw = 0; div_signed = 0; dividend = 64'h55; divisor = 0;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clock); #1;

        // flush mid-operation at T+10, new op at T+11
        start_op("flushed op", 0, 0, 64'd1000, 64'd3, 64'd333, 64'd1);
        repeat (10) junk_cycle();
        flush = 1'b1; in_valid = 1'b0; act_valid = 1'b0; cur = "flush busy";
        @(negedge clock); #1;
        flush = 1'b0;
        run_op("after flush", 0, 0, 64'd77, 64'd5, 64'd15, 64'd2);

        // asynchronous reset mid-BUSY
        start_op("reset op", 0, 0, '1, 64'd3, 64'h5555_5555_5555_5555, 64'd0);
        repeat (20) junk_cycle();
        #2;
        reset = 1'b0; in_valid = 1'b0;
        act_valid = 1'b0; hold_q = '0; hold_r = '0; cur = "in reset";
        #1;
        chk("async reset quotient", quotient, 64'd0);
        chk("async reset remainder", remainder, 64'd0);
        chk("async reset out_ready", 64'(out_ready), 64'd1);
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        @(negedge clock); #1;
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        run_op("after reset 9/3", 0, 0, 64'd9, 64'd3, 64'd3, 64'd0);
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Iterative radix-2 restoring integer divider that implements the responder side of the execute-stage divider handshake: the MDU drives operands with `in_valid`, and this block answers with `out_ready`/`out_valid`, `quotient` and `remainder`. It covers RISC-V DIV/DIVU/REM/REMU and the W variants. Each accepted operation takes one cycle per quotient bit. Divide-by-zero and signed overflow are resolved without iterating.

## Interface

- `XLEN`, default 64: datapath width. Must be 64; the W mode uses the low 32 bits.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous cancel of any in-flight operation.
- `in_valid`  in  1  operands valid; accepted when `in_valid & out_ready`.
- `divw`  in  1  1 = 32-bit operation on `[31:0]`, results sign-extended to 64 bits.
- `div_signed`  in  1  1 = two's-complement operands.
- `dividend`  in  XLEN  dividend.
- `divisor`  in  XLEN  divisor.
- `out_ready`  out  1  block idle and able to accept.
- `out_valid`  out  1  one-cycle pulse; `quotient`/`remainder` valid.
- `quotient`  out  XLEN  quotient.
- `remainder`  out  XLEN  remainder.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: `out_ready`=1. On accept, latch mode and operand magnitudes (absolute values if signed), latch the quotient and remainder sign flags, and set `cnt` = 64, or 32 if `divw`.
  - Divisor (width-truncated) == 0: go to DONE. Quotient = all ones; remainder = dividend (the W form is sign-extended from bit 31).
  - Signed, dividend = most-negative value, divisor = −1: go to DONE. Quotient = dividend; remainder = 0 (W form sign-extended).
  - Otherwise go to BUSY.
- BUSY: one restoring step per cycle.
  - Partial remainder register is XLEN+1 bits wide: shift left 1 and bring in the next dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift 1 into the quotient; otherwise shift 0.
  - Decrement `cnt`. When `cnt` reaches 1, go to DONE.
- DONE: `out_valid`=1 for exactly one cycle, then return to IDLE.
  - Quotient is negated if the dividend and divisor signs differ (signed only).
  - Remainder takes the dividend's sign.
  - W mode sign-extends bit 31 of both results, for both signed and unsigned variants.
- `quotient`/`remainder` are registered. They hold their last value until the next DONE.
- `out_ready`=0 in BUSY and DONE. Operands presented then are ignored; the MDU must hold `in_valid`.
- `flush`=1 in any state: next state IDLE, `out_valid`=0 next cycle, results unchanged. `flush` takes priority over accept in the same cycle.
- `reset` asserted (low) at any time: immediately IDLE, `cnt`=0, `out_valid`=0, `quotient`=0, `remainder`=0. Because `out_ready` is a function of state, it is 1 during reset.

## Timing

- Accept in cycle T.
  - 64-bit: BUSY for T+1..T+64, `out_valid` in T+65.
  - W mode: `out_valid` in T+33.
  - Special cases: `out_valid` in T+1.
- `out_ready` returns to 1 in the cycle after `out_valid`. Back-to-back throughput is 1 op per N+2 cycles.
- No combinational path from inputs to outputs.

## Structure

- Shared package `mdu_pkg`:
  - Enum `div_state_e` {IDLE, BUSY, DONE}.
  - Constants `XLEN`=64, `WLEN`=32.
  - Function `sext32`.
- One sub-module, `div_sign_adjust` (combinational). It performs operand absolute-value on entry and the final negate plus sign-extension on exit, and is instantiated twice.
- Top level holds the FSM, `cnt`, and the partial remainder and quotient registers.

## Test plan

- Unsigned 64-bit: 100 / 7 -> `quotient`=14, `remainder`=2, `out_valid` exactly in T+65, `out_ready`=0 during T+1..T+65.
- Signed 64-bit: −7 / 2 -> `quotient`=0xFFFF_FFFF_FFFF_FFFD, `remainder`=0xFFFF_FFFF_FFFF_FFFF. Also 7 / −2 -> `quotient`=−3, `remainder`=1.
- Special cases, each with `out_valid` in T+1:
  - 0x1234 / 0 -> `quotient`=0xFFFF_FFFF_FFFF_FFFF, `remainder`=0x1234.
  - Signed 0x8000_0000_0000_0000 / −1 -> `quotient`=0x8000_0000_0000_0000, `remainder`=0.
- W mode: `divw`=1, unsigned, `dividend`=0x1_FFFF_FFFF, `divisor`=1 -> `quotient`=0xFFFF_FFFF_FFFF_FFFF (upper input bits ignored, result sign-extended), `remainder`=0, `out_valid` in T+33.
- Flush at T+10 of a 64-bit op -> no `out_valid`, `out_ready`=1 at T+11. A new op accepted at T+11 completes correctly at T+76.
- Reset low mid-BUSY -> outputs zero asynchronously, `out_ready`=1. After release, 9 / 3 -> `quotient`=3, `remainder`=0.
